fp_requant: RTL and testbench

- Downstream stage of the fixed-point adder. Consumes its wide signed sum in Q(IN_INT).(IN_FRAC) format.
- Rounds the sum to the nearest value and saturates it to a narrower signed Q(OUT_INT).(OUT_FRAC) result.
- Two-stage pipeline with valid/ready handshake on both sides.
- Reports per-sample overflow/underflow, a sticky saturation flag and a saturating event counter for software monitoring.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_round_shift.sv | 28 ++
 rtl/fp_requant.sv | 114 +++++++++++
 tb/tb_fp_requant.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared fixed-point requantisation helpers: output width, saturation bounds and rounding mode.
package fp_pkg;

  typedef enum logic [0:0] {
    ROUND_HALF_UP = 1'b0
  } round_mode_e;

  function automatic int out_width(input int out_int, input int out_frac);
    return out_int + out_frac;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/fp_round_shift.sv
// Combinational round-to-nearest (ties toward +inf) and arithmetic right shift by SH.
// Result is one bit wider than the input so the rounding bias cannot wrap.
module fp_round_shift
  import fp_pkg::*;
#(
  parameter int          IN_W = 13,
  parameter int          SH   = 2,
  parameter round_mode_e MODE = ROUND_HALF_UP
) (
  input  logic signed [IN_W-1:0] din_i,
  output logic signed [IN_W:0]   dout_o
);

  logic signed [IN_W:0] ext;
  assign ext = {din_i[IN_W-1], din_i};

  generate
    if (SH > 0) begin : g_round
      localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (SH - 1);
      logic signed [IN_W:0] biased;
      assign biased = ext + HALF;
      assign dout_o = biased >>> SH;
    end else begin : g_pass
      assign dout_o = ext;
    end
  endgenerate

endmodule

// File: rtl/fp_requant.sv
// Two-stage round-then-saturate requantiser with per-sample clamp flags and a saturating event counter.
// Latency 2; in_ready is combinational from out_ready (no skid buffer), full throughput when unstalled.
module fp_requant
  import fp_pkg::*;
#(
  parameter int IN_INT   = 8,
  parameter int IN_FRAC  = 5,
  parameter int OUT_INT  = 4,
  parameter int OUT_FRAC = 3,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_INT+IN_FRAC-1:0]    in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [OUT_INT+OUT_FRAC-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_ovf,
  output logic                         out_unf,
  output logic                         sat_sticky,
  output logic [CNT_W-1:0]             sat_count,
  input  logic                         sat_clr
);

  localparam int IN_W = IN_INT + IN_FRAC;
  localparam int RW   = IN_W + 1;
  localparam int W    = out_width(OUT_INT, OUT_FRAC);
  localparam int SH   = IN_FRAC - OUT_FRAC;

  localparam logic signed [RW-1:0] MAX_R = RW'(sat_max(W));
  localparam logic signed [RW-1:0] MIN_R = RW'(sat_min(W));
  localparam logic [W-1:0]         MAX_O = W'(sat_max(W));
  localparam logic [W-1:0]         MIN_O = W'(sat_min(W));

  logic signed [RW-1:0] r_d, s1_r_q;
  logic                 s1_vld_q;
  logic [W-1:0]         data_d, data_q;
  logic                 ovf_d, unf_d, ovf_q, unf_q, vld_q;
  logic                 sticky_d, sticky_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 s1_adv, s2_adv, clamp;

  fp_round_shift #(
    .IN_W (IN_W),
    .SH   (SH),
    .MODE (ROUND_HALF_UP)
  ) u_round (
    .din_i  ($signed(in_data)),
    .dout_o (r_d)
  );

  assign s2_adv   = !vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    data_d = s1_r_q[W-1:0];
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (s1_r_q > MAX_R) begin
      data_d = MAX_O;
      ovf_d  = 1'b1;
    end else if (s1_r_q < MIN_R) begin
      data_d = MIN_O;
      unf_d  = 1'b1;
    end
  end

  // Clamp events count only on the output handshake; a clear in the same cycle is applied first.
  always_comb begin
    clamp    = vld_q && out_ready && (ovf_q || unf_q);
    sticky_d = (sticky_q && !sat_clr) || clamp;
    cnt_d    = sat_clr ? '0 : cnt_q;
    if (clamp && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_r_q   <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= in_valid;
        if (in_valid) s1_r_q <= r_d;
      end
      if (s2_adv) begin
        vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          data_q <= data_d;
          ovf_q  <= ovf_d;
          unf_q  <= unf_d;
        end
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = vld_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;
  assign sat_sticky = sticky_q;
  assign sat_count  = cnt_q;

endmodule

// File: tb/tb_fp_requant.sv
// Directed-vector bench for fp_requant at default parameters (Q8.5 in, Q4.3 out).
module tb_fp_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_ovf;
  logic        out_unf;
  logic        sat_sticky;
  logic [15:0] sat_count;
  logic        sat_clr;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  fp_requant dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count),
    .sat_clr    (sat_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    tick(); tick();
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 7'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
    if (out_unf !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", out_unf); end
    if (sat_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", sat_sticky); end
    if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sat_count); end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Rounding cases, no saturation: 19->5, tie 18->5, -18->-4, -2 tie->0, -3->-1, 252->63, -256->-64.
  task automatic test_round;
    logic [12:0] din [7];
    logic [6:0]  exp_o [7];
    din[0] = 13'd19;   exp_o[0] = 7'h05;
    din[1] = 13'd18;   exp_o[1] = 7'h05;
    din[2] = -13'sd18; exp_o[2] = 7'h7C;
    din[3] = -13'sd2;  exp_o[3] = 7'h00;
    din[4] = -13'sd3;  exp_o[4] = 7'h7F;
    din[5] = 13'd252;  exp_o[5] = 7'h3F;
    din[6] = -13'sd256; exp_o[6] = 7'h40;
    for (int i = 0; i < 7; i++) begin
      in_data = din[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== exp_o[i]) begin errors++; $display("FAIL round_data[%0d]: got %h expected %h", i, out_data, exp_o[i]); end
      if (out_ovf !== 1'b0) begin errors++; $display("FAIL round_ovf[%0d]: got %b expected 0", i, out_ovf); end
      if (out_unf !== 1'b0) begin errors++; $display("FAIL round_unf[%0d]: got %b expected 0", i, out_unf); end
    end
    tick();
  endtask

  task automatic test_saturate;
    logic [12:0] din [4];
    logic [6:0]  exp_o [4];
    logic        e_ovf [4];
    din[0] = 13'd256;   exp_o[0] = 7'h3F; e_ovf[0] = 1'b1;
    din[1] = -13'sd288; exp_o[1] = 7'h40; e_ovf[1] = 1'b0;
    din[2] = 13'd254;   exp_o[2] = 7'h3F; e_ovf[2] = 1'b1;
    din[3] = -13'sd259; exp_o[3] = 7'h40; e_ovf[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = din[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== exp_o[i]) begin errors++; $display("FAIL sat_data[%0d]: got %h expected %h", i, out_data, exp_o[i]); end
      if (out_ovf !== e_ovf[i]) begin errors++; $display("FAIL sat_ovf[%0d]: got %b expected %b", i, out_ovf, e_ovf[i]); end
      if (out_unf !== !e_ovf[i]) begin errors++; $display("FAIL sat_unf[%0d]: got %b expected %b", i, out_unf, !e_ovf[i]); end
      tick();
      exp_cnt++;
      checks += 2;
      if (sat_count !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, sat_count, exp_cnt); end
      if (sat_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky[%0d]: got %b expected 1", i, sat_sticky); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp_o;
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      in_valid = (i < 16);
      in_data  = 13'(i);
      #1;
      if (i < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        exp_o = 7'((i - 1 + 2) / 4);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i - 1, out_valid); end
        if (out_data !== exp_o) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i - 1, out_data, exp_o); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_stall;
    logic [6:0]  exp_o [4];
    logic [12:0] feed [4];
    logic        feed_v [4];
    exp_o[0] = 7'h3F; feed[0] = 13'd8;  feed_v[0] = 1'b1;
    exp_o[1] = 7'h01; feed[1] = 13'd12; feed_v[1] = 1'b1;
    exp_o[2] = 7'h02; feed[2] = 13'd0;  feed_v[2] = 1'b0;
    exp_o[3] = 7'h03; feed[3] = 13'd0;  feed_v[3] = 1'b0;
    out_ready = 1'b0;
    in_data = 13'd256; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_a: got %b expected 1", in_ready); end
    tick();
    in_data = 13'd4;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_b: got %b expected 1", in_ready); end
    tick();
    in_data = 13'd8;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks += 5;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", k, in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, out_valid); end
      if (out_data !== 7'h3F) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 3f", k, out_data); end
      if (out_ovf !== 1'b1) begin errors++; $display("FAIL stall_ovf[%0d]: got %b expected 1", k, out_ovf); end
      if (sat_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected %0d", k, sat_count, exp_cnt); end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_data = feed[j]; in_valid = feed_v[j];
      #1;
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL release_valid[%0d]: got %b expected 1", j, out_valid); end
      if (out_data !== exp_o[j]) begin errors++; $display("FAIL release_data[%0d]: got %h expected %h", j, out_data, exp_o[j]); end
      tick();
    end
    exp_cnt++;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_no_dup: got %b expected 0", out_valid); end
    if (sat_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_count_once: got %0d expected %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_sat_clr;
    out_ready = 1'b1;
    in_data = 13'd256; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_ovf !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %b expected 1", out_ovf); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    exp_cnt = 1;
    checks += 2;
    if (sat_count !== 16'd1) begin errors++; $display("FAIL clr_same_cycle_count: got %0d expected 1", sat_count); end
    if (sat_sticky !== 1'b1) begin errors++; $display("FAIL clr_same_cycle_sticky: got %b expected 1", sat_sticky); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    exp_cnt = 0;
    checks += 2;
    if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_alone_count: got %0d expected 0", sat_count); end
    if (sat_sticky !== 1'b0) begin errors++; $display("FAIL clr_alone_sticky: got %b expected 0", sat_sticky); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1;
    in_data = -13'sd288; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++;
    if (sat_count !== 16'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", sat_count); end
    out_ready = 1'b0;
    in_data = 13'd256; in_valid = 1'b1;
    tick();
    in_data = 13'd40;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", in_ready); end
    rst = 1'b0;
    tick();
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 7'h00) begin errors++; $display("FAIL mid_out_data: got %h expected 00", out_data); end
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", out_ovf); end
    if (sat_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", sat_count); end
    if (sat_sticky !== 1'b0) begin errors++; $display("FAIL mid_sticky: got %b expected 0", sat_sticky); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    rst = 1'b1;
    out_ready = 1'b1;
    in_data = 13'd19; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", out_valid); end
    tick();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid: got %b expected 1", out_valid); end
    if (out_data !== 7'h05) begin errors++; $display("FAIL mid_post_data: got %h expected 05", out_data); end
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL mid_post_ovf: got %b expected 0", out_ovf); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_drain: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_round();
    test_saturate();
    test_back_to_back();
    test_stall();
    test_sat_clr();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
